aes_uart_tx_sched: RTL and testbench
====================================

// Module: aes_uart_tx_sched
// PURPOSE
// - Shares the AES-UART TX FIFO write port between the plaintext TDR stream (s0) and AESCipher output (s1).
// - Sits in place of the static 2:1 TX mux, upstream of the TX FIFO. Both sources may then be active at once.
// - Each cipher block (BLOCK_BYTES) goes out atomically and is never interleaved with plaintext bytes.
// - Plaintext goes out in bursts of at most MAX_BURST bytes. Grants are round-robin, with an optional cipher-priority override.
// PARAMETERS
// - BLOCK_BYTES  16  beats per cipher grant (one AES block); range 1..255
// - MAX_BURST    4   max beats per plaintext grant; range 1..255
// PORTS
// - Clk          in   1  clock
// - Rst_n        in   1  asynchronous active-low reset
// - En           in   1  scheduler enable (driven from cr1.aue)
// - PrioCipher   in   1  1: s1 wins every arbitration; 0: round-robin
// - s0_axis      snk  taxi_axis_if DATA_W=8  plaintext source (tdata/tvalid/tready/tlast)
// - s1_axis      snk  taxi_axis_if DATA_W=8  cipher source; its tlast is ignored
// - m_axis       src  taxi_axis_if DATA_W=8  to TX FIFO
// - Grant        out  2  one-hot current owner: 01=s0, 10=s1, 00=none
// - Busy         out  1  1 while in GNT0 or GNT1
// BEHAVIOUR
// - Reset values: State=IDLE, Cnt=0, Last=s1 (so s0 wins the first tie), Grant=00, Busy=0.
//   Outputs at reset: m_axis.tvalid=0, m_axis.tlast=0, s0/s1 tready=0. Mid-operation reset drops the partial block.
// - States: IDLE, GNT0, GNT1. Grant and Busy are registered and decoded from State.
// - IDLE: no tready asserted and m_axis.tvalid=0. Requests are sampled when En=1. Req0=s0.tvalid, Req1=s1.tvalid.
//   - Req1 & PrioCipher -> GNT1.
//   - Else Req0 & Req1 -> the source that is not Last.
//   - Else the single requester. With no request, stay in IDLE. En=0 keeps the block in IDLE.
//   - Entering a grant state clears Cnt and loads Last with the new owner.
// - GNTx: combinational pass-through. m.tdata/tvalid = sx.tdata/tvalid, sx.tready = m.tready.
//   The other source's tready stays 0. A beat is counted when m.tvalid & m.tready.
// - m_axis.tlast = 1 only on the final beat of a grant:
//   - GNT1: when Cnt==BLOCK_BYTES-1.
//   - GNT0: when Cnt==MAX_BURST-1 or s0.tlast=1.
// - A grant ends when its final beat is accepted, and the next state is IDLE.
//   One idle arbitration cycle always separates grants, so peak throughput is N/(N+1).
// - Cnt is 8 bits. It never wraps because the grant ends at its limit.
// - En falling during GNTx: the grant runs to its normal end, so no cipher block is truncated. Then the block stays in IDLE.
// - Source tvalid dropping mid-grant: the grant is held and the block waits, with no timeout.
//   Backpressure (m.tready=0) stalls the beat and Cnt holds.
// - PrioCipher changes take effect only at the next IDLE decision, never mid-grant.
// - Zero combinational path from m.tready to any state decision except the counted-beat enable.
// CONFIGURATION
// - Macro AES_UART_TX_SCHED_STATS_EN:
//   - Defined: adds output ports Beats0 and Beats1 (32 bits each). They count accepted beats per source
//     and wrap modulo 2^32. Rst_n resets both to 0, and counting continues while En=0 for in-flight grants.
//   - Undefined: these ports and their counters are absent. All other behaviour is identical.
// TESTING
// - T1 reset: Rst_n=0 with both sources valid -> Grant=00, all tready=0, m.tvalid=0.
//   After release, the first tie goes to s0.
// - T2 atomic block: s1 streams 16 bytes 0x00..0x0F and s0 is valid throughout, PrioCipher=1.
//   -> m gets 0x00..0x0F contiguous with tlast on 0x0F, then one IDLE cycle.
// - T3 round-robin: both sources always valid, PrioCipher=0, MAX_BURST=4.
//   -> owners alternate s0(4 beats), s1(16), s0(4)... with a one-cycle gap between grants.
// - T4 early tlast: s0 sends 2 bytes with tlast on the 2nd.
//   -> grant ends after 2 beats with m.tlast=1 on beat 2, and Grant returns to 00.
// - T5 En drop: En->0 after the 5th s1 beat.
//   -> the remaining 11 beats complete, then the block stays in IDLE despite a valid s0 until En->1.
// - T6 backpressure/reset: m.tready toggles 1/0 during a block -> no beat is lost or duplicated.
//   Rst_n asserted at beat 8 -> the block returns to IDLE immediately, and the next s1 grant restarts Cnt at 0.

Source files
------------

// File: rtl/aes_uart_tx_sched.sv
// Arbitrates the AES-UART TX FIFO write port between plaintext (s0) and cipher (s1) streams.
// Optional per-source beat counters are enabled by defining AES_UART_TX_SCHED_STATS_EN.
module aes_uart_tx_sched #(
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        prio_cipher_i,
  input  logic [7:0]  s0_tdata_i,
  input  logic        s0_tvalid_i,
  input  logic        s0_tlast_i,
  output logic        s0_tready_o,
  input  logic [7:0]  s1_tdata_i,
  input  logic        s1_tvalid_i,
  output logic        s1_tready_o,
  output logic [7:0]  m_tdata_o,
  output logic        m_tvalid_o,
  output logic        m_tlast_o,
  input  logic        m_tready_i,
`ifdef AES_UART_TX_SCHED_STATS_EN
  output logic [31:0] beats0_o,
  output logic [31:0] beats1_o,
`endif
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] BLK_LAST   = 8'(BLOCK_BYTES - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d;  // 0: s0 owned last grant, 1: s1
  logic       beat;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    m_tdata_o   = 8'd0;
    m_tvalid_o  = 1'b0;
    m_tlast_o   = 1'b0;
    s0_tready_o = 1'b0;
    s1_tready_o = 1'b0;
    beat        = 1'b0;
    case (state_q)
      IDLE: begin
        // m_tready never reaches this decision; only request lines and priority do
        if (en_i) begin
          if (s1_tvalid_i && (prio_cipher_i || !s0_tvalid_i || !last_q)) begin
            state_d = GNT1;
            cnt_d   = 8'd0;
            last_d  = 1'b1;
          end else if (s0_tvalid_i) begin
            state_d = GNT0;
            cnt_d   = 8'd0;
            last_d  = 1'b0;
          end
        end
      end
      GNT0: begin
        m_tdata_o   = s0_tdata_i;
        m_tvalid_o  = s0_tvalid_i;
        m_tlast_o   = (cnt_q == BURST_LAST) || s0_tlast_i;
        s0_tready_o = m_tready_i;
        beat        = s0_tvalid_i && m_tready_i;
        if (beat) begin
          if (m_tlast_o) state_d = IDLE;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      GNT1: begin
        m_tdata_o   = s1_tdata_i;
        m_tvalid_o  = s1_tvalid_i;
        m_tlast_o   = (cnt_q == BLK_LAST);
        s1_tready_o = m_tready_i;
        beat        = s1_tvalid_i && m_tready_i;
        if (beat) begin
          if (m_tlast_o) state_d = IDLE;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o = {state_q == GNT1, state_q == GNT0};
  assign busy_o  = (state_q != IDLE);

`ifdef AES_UART_TX_SCHED_STATS_EN
  logic [31:0] beats0_q, beats1_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beats0_q <= 32'd0;
      beats1_q <= 32'd0;
    end else begin
      if (beat && state_q == GNT0) beats0_q <= beats0_q + 32'd1;
      if (beat && state_q == GNT1) beats1_q <= beats1_q + 32'd1;
    end
  end

  assign beats0_o = beats0_q;
  assign beats1_o = beats1_q;
`endif

endmodule

// File: tb/tb_aes_uart_tx_sched.sv
// Bench for aes_uart_tx_sched: grant-level model checked every cycle plus literal beat-log checks.
module tb_aes_uart_tx_sched;
  localparam int BLK = 16;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1, prio = 1'b0;
  logic [7:0] s0_tdata = 8'h80, s1_tdata = 8'h00;
  logic s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, m_tready = 1'b1;
  logic s0_tready, s1_tready, m_tvalid, m_tlast, busy;
  logic [7:0] m_tdata;
  logic [1:0] grant;
`ifdef AES_UART_TX_SCHED_STATS_EN
  logic [31:0] beats0, beats1;
  int exp_b0, exp_b1;
`endif

  aes_uart_tx_sched #(.BLOCK_BYTES(BLK), .MAX_BURST(BURST)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .prio_cipher_i(prio),
    .s0_tdata_i(s0_tdata), .s0_tvalid_i(s0_tvalid), .s0_tlast_i(s0_tlast), .s0_tready_o(s0_tready),
    .s1_tdata_i(s1_tdata), .s1_tvalid_i(s1_tvalid), .s1_tready_o(s1_tready),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
`ifdef AES_UART_TX_SCHED_STATS_EN
    .beats0_o(beats0), .beats1_o(beats1),
`endif
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int owner = 0, gcnt = 0, last_own = 2, cyc = 0;  // owner/last_own: 0 none, 1 s0, 2 s1
  bit hs0_seen = 0, hs1_seen = 0;
  int s0_idx = 0, s1_idx = 0, s0_every = 0;
  bit tog = 0;
  int log_src[$], log_cyc[$];
  logic [7:0] log_data[$];
  bit log_last[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a grant is a run of up to `limit` accepted beats from one owner,
  // separated from the next grant by one idle decision cycle.
  logic ev, et, etr0, etr1;
  logic [7:0] ed;
  int pick;
  always @(negedge clk) begin
    cyc++;
    hs0_seen = 0;
    hs1_seen = 0;
    if (!rst_n) begin
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mvalid", 32'(m_tvalid), 32'd0);
      chk("rst_mlast", 32'(m_tlast), 32'd0);
      chk("rst_tready0", 32'(s0_tready), 32'd0);
      chk("rst_tready1", 32'(s1_tready), 32'd0);
      owner = 0; gcnt = 0; last_own = 2;
`ifdef AES_UART_TX_SCHED_STATS_EN
      exp_b0 = 0; exp_b1 = 0;
`endif
    end else begin
      ev = 0; et = 0; ed = 8'h00; etr0 = 0; etr1 = 0;
      if (owner == 1) begin
        ev = s0_tvalid; ed = s0_tdata; etr0 = m_tready;
        et = (gcnt == BURST - 1) || s0_tlast;
      end else if (owner == 2) begin
        ev = s1_tvalid; ed = s1_tdata; etr1 = m_tready;
        et = (gcnt == BLK - 1);
      end
      chk("grant", 32'(grant), owner == 1 ? 32'd1 : owner == 2 ? 32'd2 : 32'd0);
      chk("busy", 32'(busy), 32'(owner != 0));
      chk("m_tvalid", 32'(m_tvalid), 32'(ev));
      chk("s0_tready", 32'(s0_tready), 32'(etr0));
      chk("s1_tready", 32'(s1_tready), 32'(etr1));
      if (ev) begin
        chk("m_tdata", 32'(m_tdata), 32'(ed));
        chk("m_tlast", 32'(m_tlast), 32'(et));
      end
`ifdef AES_UART_TX_SCHED_STATS_EN
      chk("beats0", beats0, 32'(exp_b0));
      chk("beats1", beats1, 32'(exp_b1));
`endif
      if (owner == 0) begin
        pick = 0;
        if (en) begin
          if (s1_tvalid && (prio || !s0_tvalid || last_own == 1)) pick = 2;
          else if (s0_tvalid) pick = 1;
        end
        if (pick != 0) begin
          owner = pick; gcnt = 0; last_own = pick;
        end
      end else if (ev && m_tready) begin
        log_src.push_back(owner); log_data.push_back(ed);
        log_last.push_back(et); log_cyc.push_back(cyc);
        if (owner == 1) hs0_seen = 1; else hs1_seen = 1;
`ifdef AES_UART_TX_SCHED_STATS_EN
        if (owner == 1) exp_b0++; else exp_b1++;
`endif
        if (et) owner = 0; else gcnt++;
      end
    end
  end

  task automatic drive_src();
    s0_tdata = 8'h80 + 8'(s0_idx);
    s0_tlast = (s0_every != 0) && (s0_idx % s0_every == s0_every - 1);
    s1_tdata = 8'(s1_idx);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (hs0_seen) s0_idx++;
    if (hs1_seen) s1_idx++;
    if (tog) m_tready = ~m_tready;
    drive_src();
  endtask

  task automatic clear_log();
    log_src.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    s0_idx = 0; s1_idx = 0;
    drive_src();
    repeat (3) cycle();
    rst_n = 1;
    clear_log();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (log_src.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("wait_beats", 32'(log_src.size() >= n), 32'd1);
  endtask

  initial begin
    // T1 + T3: reset with both valid, then round-robin
    en = 1; prio = 0; s0_tvalid = 1; s1_tvalid = 1; m_tready = 1; s0_every = 0;
    do_reset();
    wait_beats(24, 200);
    if (log_src.size() >= 24) begin
      chk("t1_first_tie_s0", 32'(log_src[0]), 32'd1);
      chk("t3_s0_beat3_last", 32'({log_src[3] == 1, log_last[3]}), 32'b11);
      chk("t3_s0_contig", 32'(log_cyc[3] - log_cyc[0]), 32'd3);
      chk("t3_gap0", 32'(log_cyc[4] - log_cyc[3]), 32'd2);
      chk("t3_s1_first", 32'({8'(log_src[4]), log_data[4]}), 32'h0200);
      chk("t3_s1_last", 32'({8'(log_src[19]), log_data[19], 7'd0, log_last[19]}), 32'h020F01);
      chk("t3_gap1", 32'(log_cyc[20] - log_cyc[19]), 32'd2);
      chk("t3_s0_again", 32'({8'(log_src[20]), log_data[20]}), 32'h0184);
    end

    // T2: cipher priority, atomic block
    prio = 1;
    do_reset();
    wait_beats(17, 100);
    if (log_src.size() >= 17) begin
      for (int i = 0; i < 16; i++)
        chk("t2_block", 32'({8'(log_src[i]), log_data[i]}), 32'h0200 + 32'(i));
      chk("t2_tlast", 32'({log_last[14], log_last[15]}), 32'b01);
      chk("t2_gap", 32'(log_cyc[16] - log_cyc[15]), 32'd2);
      chk("t2_prio_again", 32'(log_src[16]), 32'd2);
    end

    // T4: early tlast from s0
    prio = 0; s1_tvalid = 0; s0_every = 2;
    do_reset();
    wait_beats(2, 20);
    if (log_src.size() >= 2) begin
      chk("t4_data", 32'({log_data[0], log_data[1]}), 32'h8081);
      chk("t4_tlast", 32'({log_last[0], log_last[1]}), 32'b01);
      chk("t4_grant_idle", 32'(grant), 32'd0);
    end

    // T5: En drops mid-block
    prio = 1; s0_tvalid = 1; s1_tvalid = 1; s0_every = 0;
    do_reset();
    wait_beats(5, 30);
    en = 0;
    repeat (40) cycle();
    chk("t5_count", 32'(log_src.size()), 32'd16);
    if (log_src.size() >= 16) chk("t5_tlast", 32'(log_last[15]), 32'd1);
    chk("t5_idle", 32'(grant), 32'd0);
    s1_tvalid = 0; en = 1;
    wait_beats(17, 20);
    if (log_src.size() >= 17) chk("t5_s0_after", 32'(log_src[16]), 32'd1);

    // T6: backpressure then reset mid-block
    s0_tvalid = 0; s1_tvalid = 1; tog = 1;
    do_reset();
    wait_beats(8, 60);
    if (log_src.size() >= 8)
      for (int i = 0; i < 8; i++) chk("t6_nolossdup", 32'(log_data[i]), 32'(i));
    rst_n = 0;
    cycle();
    cycle();
    tog = 0; m_tready = 1; s1_idx = 0; drive_src();
    rst_n = 1;
    clear_log();
    wait_beats(16, 60);
    if (log_src.size() >= 16) begin
      chk("t6_restart_tlast", 32'({log_last[14], log_last[15]}), 32'b01);
      chk("t6_restart_data", 32'(log_data[15]), 32'h0F);
    end
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
